// File: rtl/otp_pad_feeder_if.sv
// Handshake bundle between the pad feeder, its seed/plaintext sources and the XOR stage.
// rnd / out_pad_m exist only when OTP_PAD_MASK_EN is defined.
interface otp_pad_feeder_if #(
    parameter int DATA_W = 8,
    parameter int LFSR_W = 16
);
    logic              seed_valid;
    logic [LFSR_W-1:0] seed;
    logic              seed_ready;
    logic              pt_valid;
    logic [DATA_W-1:0] pt_data;
    logic              pt_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_pt;
    logic [DATA_W-1:0] out_pad;
    logic              out_ready;
    logic              exhausted;
    logic [7:0]        pad_count;
`ifdef OTP_PAD_MASK_EN
    logic [DATA_W-1:0] rnd;
    logic [DATA_W-1:0] out_pad_m;

    modport master (
        output seed_valid, seed, pt_valid, pt_data, out_ready, rnd,
        input  seed_ready, pt_ready, out_valid, out_pt, out_pad, exhausted, pad_count, out_pad_m
    );
    modport slave (
        input  seed_valid, seed, pt_valid, pt_data, out_ready, rnd,
        output seed_ready, pt_ready, out_valid, out_pt, out_pad, exhausted, pad_count, out_pad_m
    );
`else
    modport master (
        output seed_valid, seed, pt_valid, pt_data, out_ready,
        input  seed_ready, pt_ready, out_valid, out_pt, out_pad, exhausted, pad_count
    );
    modport slave (
        input  seed_valid, seed, pt_valid, pt_data, out_ready,
        output seed_ready, pt_ready, out_valid, out_pt, out_pad, exhausted, pad_count
    );
`endif
endinterface

// File: rtl/otp_pad_feeder.sv
// Pairs each plaintext byte with a one-time pad byte from a seeded 16-bit LFSR, capped at
// MAX_PADS pads per seed. OTP_PAD_MASK_EN: pad leaves only as two shares (pad^rnd, rnd).
module otp_pad_feeder #(
    parameter int DATA_W   = 8,
    parameter int LFSR_W   = 16,
    parameter int MAX_PADS = 255
) (
    input logic             clk,
    input logic             reset,
    otp_pad_feeder_if.slave bus
);
    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = LFSR_W'(16'hACE1);
    localparam logic [7:0]        PAD_LIMIT     = 8'(MAX_PADS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        EXHAUSTED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [7:0]        pad_count_q, pad_count_d;
    logic              exhausted_q, exhausted_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_pt_q, out_pt_d;
    logic [DATA_W-1:0] out_pad_q, out_pad_d;
`ifdef OTP_PAD_MASK_EN
    logic [DATA_W-1:0] out_pad_m_q, out_pad_m_d;
`endif

    logic              seed_ready_s;
    logic              pt_ready_s;
    logic              seed_hs_s;
    logic              pt_hs_s;
    logic              out_hs_s;
    logic [7:0]        pad_inc_s;
    logic [DATA_W-1:0] pad_s;

    // One pad byte consumes DATA_W single LFSR steps, unrolled into one cycle.
    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s_in);
        logic [LFSR_W-1:0] s;
        s = s_in;
        for (int i = 0; i < DATA_W; i++) begin
            s = {s[LFSR_W-2:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
        return s;
    endfunction

    assign seed_ready_s = (state_q != RUN);
    assign pt_ready_s   = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    assign seed_hs_s    = bus.seed_valid && seed_ready_s;
    assign pt_hs_s      = bus.pt_valid && pt_ready_s;
    assign out_hs_s     = out_valid_q && bus.out_ready;
    assign pad_inc_s    = pad_count_q + 8'd1;
`ifdef OTP_PAD_MASK_EN
    assign pad_s        = lfsr_q[DATA_W-1:0] ^ bus.rnd;
`else
    assign pad_s        = lfsr_q[DATA_W-1:0];
`endif

    // Next state of the seed/budget FSM, LFSR, counter and output pair register.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        pad_count_d = pad_count_q;
        exhausted_d = exhausted_q;
        out_valid_d = out_valid_q;
        out_pt_d    = out_pt_q;
        out_pad_d   = out_pad_q;
`ifdef OTP_PAD_MASK_EN
        out_pad_m_d = out_pad_m_q;
`endif
        case (state_q)
            IDLE, EXHAUSTED: begin
                if (seed_hs_s) begin
                    // An all-zero state would lock the LFSR, so substitute a known seed.
                    lfsr_d      = (bus.seed == '0) ? ZERO_SEED_SUB : bus.seed;
                    pad_count_d = 8'd0;
                    exhausted_d = 1'b0;
                    state_d     = RUN;
                end else begin
                    state_d     = state_q;
                end
            end
            RUN: begin
                if (pt_hs_s) begin
                    lfsr_d      = lfsr_advance(lfsr_q);
                    pad_count_d = pad_inc_s;
                    if (pad_inc_s == PAD_LIMIT) begin
                        state_d     = EXHAUSTED;
                        exhausted_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pt_hs_s) begin
            out_valid_d = 1'b1;
            out_pt_d    = bus.pt_data;
            out_pad_d   = pad_s;
`ifdef OTP_PAD_MASK_EN
            out_pad_m_d = bus.rnd;
`endif
        end else if (out_hs_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers; reset drops any pending pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lfsr_q      <= '0;
            pad_count_q <= 8'd0;
            exhausted_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_pt_q    <= '0;
            out_pad_q   <= '0;
`ifdef OTP_PAD_MASK_EN
            out_pad_m_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            pad_count_q <= pad_count_d;
            exhausted_q <= exhausted_d;
            out_valid_q <= out_valid_d;
            out_pt_q    <= out_pt_d;
            out_pad_q   <= out_pad_d;
`ifdef OTP_PAD_MASK_EN
            out_pad_m_q <= out_pad_m_d;
`endif
        end
    end

    assign bus.seed_ready = seed_ready_s;
    assign bus.pt_ready   = pt_ready_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pt     = out_pt_q;
    assign bus.out_pad    = out_pad_q;
    assign bus.exhausted  = exhausted_q;
    assign bus.pad_count  = pad_count_q;
`ifdef OTP_PAD_MASK_EN
    assign bus.out_pad_m  = out_pad_m_q;
`endif

endmodule

// File: tb/tb_otp_pad_feeder.sv
// Self-checking bench for otp_pad_feeder: directed steps plus randomized traffic against a
// transaction-level reference model (budgeted pad stream per seed, one-deep output slot).
module tb_otp_pad_feeder;
    localparam int DW = 8;
    localparam int LW = 16;
    localparam int MP = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    otp_pad_feeder_if #(.DATA_W(DW), .LFSR_W(LW)) bus ();

    otp_pad_feeder #(.DATA_W(DW), .LFSR_W(LW), .MAX_PADS(MP)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a seed opens a stream of MP pads; a single output slot holds a pair.
    bit          m_live;
    bit          m_exh;
    int          m_cnt;
    logic [15:0] m_lfsr;
    bit          m_ov;
    logic [7:0]  m_pt;
    logic [7:0]  m_pad;
    logic [7:0]  m_padm;
    logic [7:0]  rnd_v;
    logic [15:0] tmp16;

    function automatic logic [15:0] ref_next(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int k = 0; k < 8; k++) begin
            t = {t[14:0], 1'b0} | {15'd0, ^(t & 16'hB400)};
        end
        return t;
    endfunction

    function automatic logic [7:0] raw_pad();
`ifdef OTP_PAD_MASK_EN
        return bus.out_pad ^ bus.out_pad_m;
`else
        return bus.out_pad;
`endif
    endfunction

    task automatic m_reset();
        m_live = 1'b0;
        m_exh  = 1'b0;
        m_cnt  = 0;
        m_lfsr = 16'h0000;
        m_ov   = 1'b0;
        m_pt   = 8'h00;
        m_pad  = 8'h00;
        m_padm = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check DUT against the model, then advance both by one edge.
    task automatic cycle(input bit sv, input logic [15:0] sd, input bit pv,
                         input logic [7:0] pd, input bit ordy);
        bit exp_ptr, exp_sr, pt_hs, out_hs, seed_hs;
        bus.seed_valid = sv;
        bus.seed       = sd;
        bus.pt_valid   = pv;
        bus.pt_data    = pd;
        bus.out_ready  = ordy;
`ifdef OTP_PAD_MASK_EN
        bus.rnd        = rnd_v;
`endif
        #1;
        exp_ptr = m_live && (!m_ov || ordy);
        exp_sr  = !m_live;
        chk("pt_ready",   16'(bus.pt_ready),   16'(exp_ptr));
        chk("seed_ready", 16'(bus.seed_ready), 16'(exp_sr));
        chk("out_valid",  16'(bus.out_valid),  16'(m_ov));
        chk("exhausted",  16'(bus.exhausted),  16'(m_exh));
        chk("pad_count",  16'(bus.pad_count),  16'(m_cnt));
        if (m_ov) begin
            chk("out_pt",  16'(bus.out_pt),  16'(m_pt));
            chk("out_pad", 16'(bus.out_pad), 16'(m_pad));
`ifdef OTP_PAD_MASK_EN
            chk("out_pad_m", 16'(bus.out_pad_m), 16'(m_padm));
`endif
        end
        pt_hs   = exp_ptr && pv;
        out_hs  = m_ov && ordy;
        seed_hs = exp_sr && sv;
        if (pt_hs) begin
            m_ov   = 1'b1;
            m_pt   = pd;
`ifdef OTP_PAD_MASK_EN
            m_pad  = m_lfsr[7:0] ^ rnd_v;
            m_padm = rnd_v;
`else
            m_pad  = m_lfsr[7:0];
`endif
            m_lfsr = ref_next(m_lfsr);
            m_cnt++;
            if (m_cnt == MP) begin
                m_live = 1'b0;
                m_exh  = 1'b1;
            end
        end else if (out_hs) begin
            m_ov = 1'b0;
        end
        if (seed_hs) begin
            m_lfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
            m_cnt  = 0;
            m_exh  = 1'b0;
            m_live = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.seed_valid = 1'b0;
        bus.seed       = 16'h0000;
        bus.pt_valid   = 1'b0;
        bus.pt_data    = 8'h00;
        bus.out_ready  = 1'b0;
        rnd_v          = 8'h5A;
`ifdef OTP_PAD_MASK_EN
        bus.rnd        = 8'h00;
`endif
        m_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seed_ready", 16'(bus.seed_ready), 16'h0001);
        chk("rst_pt_ready",   16'(bus.pt_ready),   16'h0000);
        chk("rst_out_valid",  16'(bus.out_valid),  16'h0000);
        chk("rst_exhausted",  16'(bus.exhausted),  16'h0000);
        chk("rst_pad_count",  16'(bus.pad_count),  16'h0000);
        chk("rst_out_pt",     16'(bus.out_pt),     16'h0000);
        chk("rst_out_pad",    16'(bus.out_pad),    16'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Seed path and first pair
        cycle(1'b1, 16'h1234, 1'b0, 8'h00, 1'b0);
        chk("seed_cnt_clear", 16'(bus.pad_count), 16'h0000);
        cycle(1'b0, 16'h0000, 1'b1, 8'hA5, 1'b0);
        chk("first_valid", 16'(bus.out_valid), 16'h0001);
        chk("first_pt",    16'(bus.out_pt),    16'h00A5);
        chk("first_cnt",   16'(bus.pad_count), 16'h0001);
`ifdef OTP_PAD_MASK_EN
        chk("mask_share0", 16'(bus.out_pad),   16'h006E);
        chk("mask_share1", 16'(bus.out_pad_m), 16'h005A);
`endif
        chk("first_pad",   16'(raw_pad()),     16'h0034);

        // Backpressure: pair must hold, nothing accepted
        repeat (5) cycle(1'b0, 16'h0000, 1'b1, 8'h3C, 1'b0);
        chk("bp_hold_pt",  16'(bus.out_pt), 16'h00A5);
        chk("bp_hold_pad", 16'(raw_pad()),  16'h0034);
        cycle(1'b0, 16'h0000, 1'b1, 8'h11, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1, 8'h22, 1'b1);

        // Exhaustion after MP accepts
        chk("exh_flag",       16'(bus.exhausted),  16'h0001);
        chk("exh_cnt",        16'(bus.pad_count),  16'h0003);
        chk("exh_pt_ready",   16'(bus.pt_ready),   16'h0000);
        chk("exh_seed_ready", 16'(bus.seed_ready), 16'h0001);
        cycle(1'b1, 16'h00FF, 1'b1, 8'h33, 1'b1);
        chk("reseed_exh", 16'(bus.exhausted), 16'h0000);
        chk("reseed_cnt", 16'(bus.pad_count), 16'h0000);
        cycle(1'b0, 16'h0000, 1'b1, 8'h44, 1'b1);
        chk("reseed_pad", 16'(raw_pad()), 16'h00FF);
        cycle(1'b0, 16'h0000, 1'b1, 8'h45, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1, 8'h46, 1'b1);

        // Zero seed substitution
        cycle(1'b1, 16'h0000, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1, 8'h55, 1'b1);
        chk("zero_seed_pad0", 16'(raw_pad()), 16'h00E1);
        cycle(1'b0, 16'h0000, 1'b1, 8'h66, 1'b1);
        tmp16 = ref_next(16'hACE1);
        chk("zero_seed_pad1", 16'(raw_pad()), 16'(tmp16[7:0]));
        cycle(1'b0, 16'h0000, 1'b1, 8'h67, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] rs;
            rnd_v = 8'($urandom);
            rs    = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            cycle($urandom_range(0, 3) == 0, rs, $urandom_range(0, 3) != 0,
                  8'($urandom), $urandom_range(0, 2) != 0);
        end

        // Asynchronous reset with a pending pair
        rnd_v = 8'h5A;
        for (int k = 0; k < 4 && m_live; k++) cycle(1'b0, 16'h0000, 1'b1, 8'h10, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 16'hBEEF, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1, 8'h77, 1'b0);
        chk("pre_rst_valid", 16'(bus.out_valid), 16'h0001);
        chk("pre_rst_cnt",   16'(bus.pad_count), 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid",      16'(bus.out_valid),  16'h0000);
        chk("async_rst_seed_ready", 16'(bus.seed_ready), 16'h0001);
        chk("async_rst_cnt",        16'(bus.pad_count),  16'h0000);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 16'h1234, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 8'h00, 1'b1);
        chk("post_rst_pad", 16'(raw_pad()), 16'h0034);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/otp_pad_feeder.md
# otp_pad_feeder

Upstream stage of the XOR encryption datapath. It pairs each incoming plaintext byte with a fresh one-time pad byte from a seeded 16-bit LFSR and presents the pair to the XOR stage through a registered valid/ready interface. It counts pads issued per seed and stops issuing pads when the budget is spent, so no pad stream is reused without an explicit reseed.

## Interface
Parameters:
- DATA_W, 8: plaintext and pad width; must be ≤ LFSR_W.
- LFSR_W, 16: LFSR state width; fixed polynomial below, valid only at 16.
- MAX_PADS, 255: pads issued per seed before exhaustion; range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- seed_valid  in  1  seed offer.
- seed  in  LFSR_W  LFSR seed value.
- seed_ready  out  1  seed accepted this cycle when high together with seed_valid.
- pt_valid  in  1  plaintext offer.
- pt_data  in  DATA_W  plaintext byte.
- pt_ready  out  1  plaintext accepted when high together with pt_valid.
- out_valid  out  1  output pair valid.
- out_pt  out  DATA_W  plaintext byte passed through.
- out_pad  out  DATA_W  pad byte, or pad share 0 under OTP_PAD_MASK_EN.
- out_ready  in  1  downstream accepts the pair.
- exhausted  out  1  pad budget for the current seed is spent.
- pad_count  out  8  pads issued since the last seed.

## Operation
- The FSM has three states: IDLE, RUN and EXHAUSTED. Reset enters IDLE.
- IDLE or EXHAUSTED:
  - seed_ready = 1.
  - On a seed handshake, load the LFSR, clear pad_count and go to RUN.
  - A seed of 0 loads 16'hACE1 instead, because a zero state locks up the LFSR.
- RUN:
  - seed_ready = 0. Reseeding mid-stream is not possible.
  - pt_ready = (state == RUN) && (!out_valid || out_ready).
- Plaintext handshake:
  - out_pt ← pt_data and out_pad ← lfsr[DATA_W-1:0], sampled before the advance.
  - out_valid ← 1.
  - The LFSR advances DATA_W steps in the same cycle, unrolled combinationally.
  - pad_count increments.
- LFSR: Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Each step shifts left, and bit0 receives s[15]^s[13]^s[12]^s[10].
- When a handshake brings pad_count to MAX_PADS, the state becomes EXHAUSTED on the same edge and exhausted = 1.
- The pending output pair still drains normally in EXHAUSTED.
- Output handshake (out_valid && out_ready) with no new plaintext accept: out_valid ← 0.
- Output accept and plaintext accept in the same cycle: the register reloads and out_valid stays 1. This gives full throughput.
- Holding rule: while out_valid = 1 and out_ready = 0, out_pt and out_pad hold stable.

## Timing
- Reset values:
  - State is IDLE.
  - seed_ready = 1; pt_ready = 0; out_valid = 0; exhausted = 0.
  - pad_count = 0; out_pt = 0; out_pad = 0; LFSR = 0.
- Reset asserted mid-operation clears everything asynchronously, and any pending output pair is lost.
- Latency: a plaintext accepted on edge N appears with out_valid = 1 after edge N. Throughput is one pair per cycle.
- Seed handshake on edge N: pt_ready can first be 1 in the cycle after edge N.
- EXHAUSTED with a seed handshake in the same cycle: pt_ready stays 0 that cycle.
- Outputs are registered only, except pt_ready and seed_ready, which are combinational from state, out_valid and out_ready.

## Configuration
- OTP_PAD_MASK_EN defined:
  - Adds input rnd [DATA_W-1:0], which carries fresh randomness every cycle.
  - Adds output out_pad_m [DATA_W-1:0].
  - On a plaintext handshake: out_pad ← pad ^ rnd and out_pad_m ← rnd.
  - The pad is never held unshared in an output register.
  - out_pad_m resets to 0 and holds under backpressure like out_pad.
- OTP_PAD_MASK_EN undefined: rnd and out_pad_m do not exist, and out_pad carries the raw pad.

## Test plan
- Seed path: reset released, seed 16'h1234 handshake, then pt_data 8'hA5 accepted → one cycle later out_valid = 1, out_pt = 8'hA5, out_pad = 8'h34, pad_count = 1.
- Zero seed: seed 16'h0000 → first pad is 8'hE1. The second pad matches a reference model that advances 16'hACE1 by 8 steps.
- Backpressure: out_ready = 0 for 5 cycles with pt_valid held high → pt_ready = 0, out_pt and out_pad stable. Releasing out_ready gives one pair per cycle with no loss and no duplication.
- Exhaustion, with MAX_PADS = 3: after 3 accepts, exhausted = 1, pt_ready = 0 and seed_ready = 1. Reseeding with 16'h00FF gives exhausted = 0, pad_count = 0 and a first pad of 8'hFF.
- Reset mid-stream: reset low while out_valid = 1 → out_valid = 0, seed_ready = 1, pad_count = 0 immediately, without waiting for a clock edge.
- With OTP_PAD_MASK_EN: seed 16'h1234, rnd = 8'h5A, pt 8'h00 → out_pad = 8'h6E, out_pad_m = 8'h5A, and out_pad ^ out_pad_m = 8'h34.
